fifo_sync_param: RTL

//  Parametrised single-clock FIFO; next generation of the 8x16 memory FIFO.

---
 rtl/fifo_sync_param.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// read-valid strobe, synchronous flush and sticky overflow/underflow errors.
module fifo_sync_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic              re,
  input  logic              flush,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] w_ptr;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_n;
  logic [PTR_W-1:0] r_ptr_n;
  logic [PTR_W-1:0] count_n;
  logic             wr_ok_c;
  logic             rd_ok_c;
  logic             overflow_n;
  logic             underflow_n;
  logic             empty_n;
  logic             full_n;
  logic             almost_empty_n;
  logic             almost_full_n;

  // Next-state: accept decisions use the current registered flags; flush masks both ports.
  always_comb begin
    wr_ok_c     = we && !full && !flush;
    rd_ok_c     = re && !empty && !flush;
    w_ptr_n     = w_ptr;
    r_ptr_n     = r_ptr;
    count_n     = count;
    overflow_n  = overflow;
    underflow_n = underflow;

    if (flush) begin
      w_ptr_n = '0;
      r_ptr_n = '0;
      count_n = '0;
    end else begin
      if (wr_ok_c) w_ptr_n = w_ptr + PTR_W'(1);
      if (rd_ok_c) r_ptr_n = r_ptr + PTR_W'(1);
      if (wr_ok_c && !rd_ok_c) begin
        count_n = count + PTR_W'(1);
      end else if (rd_ok_c && !wr_ok_c) begin
        count_n = count - PTR_W'(1);
      end
      if (we && full)  overflow_n  = 1'b1;
      if (re && empty) underflow_n = 1'b1;
    end

    // Clearing wins over a same-cycle error event.
    if (clr_err) begin
      overflow_n  = 1'b0;
      underflow_n = 1'b0;
    end

    empty_n        = (w_ptr_n == r_ptr_n);
    full_n         = (w_ptr_n[ADDR_W] != r_ptr_n[ADDR_W]) &&
                     (w_ptr_n[ADDR_W-1:0] == r_ptr_n[ADDR_W-1:0]);
    almost_empty_n = (count_n <= AE_THR);
    almost_full_n  = (count_n >= AF_THR);
  end

  // Control and status registers; flags are registered from next-state pointers
  // so they always describe the current registered occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      data_out     <= '0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      w_ptr        <= w_ptr_n;
      r_ptr        <= r_ptr_n;
      count        <= count_n;
      rd_valid     <= rd_ok_c;
      overflow     <= overflow_n;
      underflow    <= underflow_n;
      empty        <= empty_n;
      full         <= full_n;
      almost_empty <= almost_empty_n;
      almost_full  <= almost_full_n;
      if (rd_ok_c) data_out <= mem[r_ptr[ADDR_W-1:0]];
    end
  end

  // Storage array is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_c) mem[w_ptr[ADDR_W-1:0]] <= data_in;
  end

endmodule
